// File: rtl/bullcow_turn_ctrl.sv
// bullcow_turn_ctrl: debounced match sequencer for Bulls and Cows.
// Optional per-turn timeout is built when BULLCOW_TURN_TIMEOUT_EN is defined.
module bullcow_turn_ctrl #(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter,
  input  logic [15:0] SW,
  input  logic        result_valid,
  input  logic [2:0]  bull_count,
  output logic        secret_we,
  output logic        secret_sel,
  output logic        guess_strobe,
  output logic        guess_player,
  output logic [15:0] code_out,
  output logic [2:0]  game_state,
  output logic [7:0]  J1_points,
  output logic [7:0]  J2_points,
  output logic [7:0]  guess_count,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [2:0] {
    SET_J1   = 3'd0,
    SET_J2   = 3'd1,
    GUESS_J1 = 3'd2,
    WAIT_J1  = 3'd3,
    GUESS_J2 = 3'd4,
    WAIT_J2  = 3'd5,
    WIN      = 3'd6
  } state_e;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [DW-1:0] deb_q;
  logic [DW-1:0] deb_d;
  logic          press_q;
  logic          press_d;

  // Counter parks at DEB_MAX so a held button yields one press only.
  always_comb begin
    deb_d   = deb_q;
    press_d = 1'b0;
    if (!sync2_q) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d   = deb_q + 1'b1;
      press_d = (deb_q == DEB_LAST);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= enter;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       digits_ok;
  logic       distinct_ok;
  logic       code_ok;

  assign d3 = SW[15:12];
  assign d2 = SW[11:8];
  assign d1 = SW[7:4];
  assign d0 = SW[3:0];

  assign digits_ok = (d3 <= 4'd9) && (d2 <= 4'd9)
                  && (d1 <= 4'd9) && (d0 <= 4'd9);

  assign distinct_ok = (d3 != d2) && (d3 != d1) && (d3 != d0)
                    && (d2 != d1) && (d2 != d0) && (d1 != d0);

  assign code_ok = digits_ok && distinct_ok;

  state_e      state_q;
  state_e      state_d;
  logic        swe_q;
  logic        swe_d;
  logic        sel_q;
  logic        sel_d;
  logic        gs_q;
  logic        gs_d;
  logic        gp_q;
  logic        gp_d;
  logic [15:0] code_q;
  logic [15:0] code_d;
  logic [7:0]  j1_q;
  logic [7:0]  j1_d;
  logic [7:0]  j2_q;
  logic [7:0]  j2_d;
  logic [7:0]  gc_q;
  logic [7:0]  gc_d;
  logic        err_q;
  logic        err_d;
  logic        to_q;
  logic        to_d;
  logic [7:0]  gc_inc;
  logic [7:0]  j1_inc;
  logic [7:0]  j2_inc;

  assign gc_inc = (gc_q == 8'hFF) ? gc_q : gc_q + 8'd1;
  assign j1_inc = (j1_q >= 8'd99) ? j1_q : j1_q + 8'd1;
  assign j2_inc = (j2_q >= 8'd99) ? j2_q : j2_q + 8'd1;

`ifdef BULLCOW_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    swe_d   = 1'b0;
    sel_d   = sel_q;
    gs_d    = 1'b0;
    gp_d    = gp_q;
    code_d  = code_q;
    j1_d    = j1_q;
    j2_d    = j2_q;
    gc_d    = gc_q;
    err_d   = err_q;
    to_d    = 1'b0;
`ifdef BULLCOW_TURN_TIMEOUT_EN
    tcnt_d  = '0;
`endif
    unique case (state_q)
      SET_J1: begin
        if (press_q) begin
          err_d = ~code_ok;
          if (code_ok) begin
            swe_d   = 1'b1;
            sel_d   = 1'b0;
            code_d  = SW;
            state_d = SET_J2;
          end
        end
      end
      SET_J2: begin
        if (press_q) begin
          err_d = ~code_ok;
          if (code_ok) begin
            swe_d   = 1'b1;
            sel_d   = 1'b1;
            code_d  = SW;
            gc_d    = 8'd0;
            state_d = GUESS_J1;
          end
        end
      end
      GUESS_J1: begin
        if (press_q) begin
          err_d = ~code_ok;
          if (code_ok) begin
            gs_d    = 1'b1;
            gp_d    = 1'b0;
            code_d  = SW;
            gc_d    = gc_inc;
            state_d = WAIT_J1;
          end
        end
`ifdef BULLCOW_TURN_TIMEOUT_EN
        else if (tcnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = GUESS_J2;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      WAIT_J1: begin
        if (result_valid) begin
          if (bull_count == 3'd4) begin
            j1_d    = j1_inc;
            state_d = WIN;
          end else begin
            state_d = GUESS_J2;
          end
        end
      end
      GUESS_J2: begin
        if (press_q) begin
          err_d = ~code_ok;
          if (code_ok) begin
            gs_d    = 1'b1;
            gp_d    = 1'b1;
            code_d  = SW;
            gc_d    = gc_inc;
            state_d = WAIT_J2;
          end
        end
`ifdef BULLCOW_TURN_TIMEOUT_EN
        else if (tcnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = GUESS_J1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      WAIT_J2: begin
        if (result_valid) begin
          if (bull_count == 3'd4) begin
            j2_d    = j2_inc;
            state_d = WIN;
          end else begin
            state_d = GUESS_J1;
          end
        end
      end
      WIN: begin
        if (press_q) begin
          err_d   = ~code_ok;
          state_d = SET_J1;
        end
      end
      default: begin
        state_d = SET_J1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SET_J1;
      swe_q   <= 1'b0;
      sel_q   <= 1'b0;
      gs_q    <= 1'b0;
      gp_q    <= 1'b0;
      code_q  <= 16'd0;
      j1_q    <= 8'd0;
      j2_q    <= 8'd0;
      gc_q    <= 8'd0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      swe_q   <= swe_d;
      sel_q   <= sel_d;
      gs_q    <= gs_d;
      gp_q    <= gp_d;
      code_q  <= code_d;
      j1_q    <= j1_d;
      j2_q    <= j2_d;
      gc_q    <= gc_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

`ifdef BULLCOW_TURN_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`endif

  assign secret_we    = swe_q;
  assign secret_sel   = sel_q;
  assign guess_strobe = gs_q;
  assign guess_player = gp_q;
  assign code_out     = code_q;
  assign game_state   = state_q;
  assign J1_points    = j1_q;
  assign J2_points    = j2_q;
  assign guess_count  = gc_q;
  assign err          = err_q;
  assign timeout      = to_q;

endmodule
